sci_sync_fifo_th: RTL
=====================

# sci_sync_fifo_th

Parametrised synchronous FIFO for the SCI/UART TX and RX data paths, generalising the existing 4-entry UART FIFO. It adds a full-range occupancy count, programmable almost-full and almost-empty thresholds, and guarded write/read acceptance. It also reports sticky overflow/underflow errors. It sits between the SCI bus-side register interface and the UART shifter, on a single clock domain.

## Interface
- N, 16, data width in bits
- D_N, 2, log2 of depth
- DEPTH, 4, entry count; must equal 2**D_N
- AF_TH, 3, oWR_ALMOST_FULL asserts when count >= AF_TH (1..DEPTH)
- AE_TH, 1, oRD_ALMOST_EMPTY asserts when count <= AE_TH (0..DEPTH-1)

- iCLOCK  in  1  clock, rising edge
- inRESET  in  1  reset, asynchronous, active-low
- iREMOVE  in  1  synchronous flush
- iERR_CLEAR  in  1  synchronous clear of the sticky error flags
- oCOUNT  out  D_N+1  occupancy, 0..DEPTH
- iWR_EN  in  1  write request
- iWR_DATA  in  N  write data
- oWR_FULL  out  1  count == DEPTH
- oWR_ALMOST_FULL  out  1  count >= AF_TH
- iRD_EN  in  1  read request (pop)
- oRD_DATA  out  N  head entry, show-ahead
- oRD_EMPTY  out  1  count == 0
- oRD_ALMOST_EMPTY  out  1  count <= AE_TH
- oOVERFLOW  out  1  sticky: a write was rejected
- oUNDERFLOW  out  1  sticky: a read was rejected

## Operation
- Write and read pointers are D_N+1 bits wide; the low D_N bits address memory.
- count = wp - rp, computed modulo 2**(D_N+1); always in 0..DEPTH.
- Read acceptance: rd_ok = iRD_EN & !empty.
- Write acceptance: wr_ok = iWR_EN & (!full | rd_ok).
  - When full, a simultaneous valid read frees a slot, so the write is accepted.
  - When empty, a simultaneous write is accepted and the read is rejected. Reads never bypass writes.
- On an accepted write, mem[wp[D_N-1:0]] <= iWR_DATA and wp increments. On an accepted read, rp increments.
- Pointers wrap naturally through 2**(D_N+1). No special case is needed at the DEPTH boundary.
- oRD_DATA = mem[rp[D_N-1:0]], read asynchronously (first-word fall-through). It is don't-care while oRD_EMPTY is high.
- Rejected requests have no effect on the pointers or memory.
- iREMOVE clears both pointers and has priority over any write or read in the same cycle. Memory contents are not cleared. iREMOVE does not clear the error flags.
- Error flags:
  - oOVERFLOW sets on iWR_EN & !wr_ok.
  - oUNDERFLOW sets on iRD_EN & !rd_ok.
  - iERR_CLEAR clears both flags. If a set condition occurs in the same cycle as iERR_CLEAR, set wins.
  - Error requests raised in a cycle where iREMOVE is high are ignored.

## Timing
- Reset values: pointers 0, oCOUNT 0, oRD_EMPTY 1, oRD_ALMOST_EMPTY 1, oWR_FULL 0, oWR_ALMOST_FULL 0 (AF_TH >= 1), oOVERFLOW 0, oUNDERFLOW 0. Memory is not reset.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Status outputs are combinational from registered pointers. They change in the cycle after the accepting edge.
- Write-to-read latency is 1 cycle: data written at edge k is visible on oRD_DATA, with oRD_EMPTY low, after edge k.
- Read pop takes effect at the edge. The next entry appears on oRD_DATA after that edge.
- Sustained simultaneous write and read at any non-empty occupancy gives 1 write and 1 read per cycle with count unchanged.

## Configuration
- Macro: SCI_SYNC_FIFO_ERROR_FLAG_EN.
- Defined: the oOVERFLOW/oUNDERFLOW sticky registers and the iERR_CLEAR logic are built as described.
- Undefined: no error registers are built. oOVERFLOW and oUNDERFLOW are tied to 0 and iERR_CLEAR is ignored. Rejection of invalid writes and reads is unchanged.

## Structure
- Shared package sci_fifo_pkg holds:
  - the default width/depth constants (SCI_FIFO_N, SCI_FIFO_D_N);
  - the pointer width expression D_N+1 as a localparam helper.
- sci_sync_fifo_th contains the pointer, count, flag and error logic.
- One sub-module, sci_sync_fifo_ram: DEPTH x N register array with one synchronous write port and one asynchronous read port.

## Test plan
All scenarios use defaults N=16, DEPTH=4, AF_TH=3, AE_TH=1.
- Reset, then write 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles -> count 1,2,3,4; oRD_ALMOST_EMPTY low at count 2; oWR_ALMOST_FULL high at count 3; oWR_FULL high at count 4; oRD_DATA 0x1111 from the cycle after the first write.
- Full FIFO, write 0x5555 alone -> rejected; count stays 4; oOVERFLOW=1. Then iERR_CLEAR -> oOVERFLOW=0.
- Full FIFO, write 0x5555 together with a read -> both accepted; count stays 4; head becomes 0x2222; oOVERFLOW stays 0.
- Empty FIFO, read alone -> oUNDERFLOW=1, pointers unchanged. Empty FIFO, write 0xAAAA together with a read -> count 1, oRD_DATA 0xAAAA, oUNDERFLOW=1.
- Wrap: run 10 write/read pairs with values 0..9 at occupancy 2 -> read order preserved, count constantly 2, no flags set.
- 3 entries, iREMOVE together with a write -> count 0, oRD_EMPTY 1, write discarded. Then drop inRESET mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sci_fifo_pkg.sv
// Shared constants for the SCI FIFO family.
// Default data width, depth exponent and pointer width helper.
package sci_fifo_pkg;

  localparam int SCI_FIFO_N   = 16;
  localparam int SCI_FIFO_D_N = 2;

  // Pointers carry one extra bit to tell full from empty
  localparam int SCI_FIFO_PW  = SCI_FIFO_D_N + 1;

  function automatic int sci_fifo_ptr_w(input int d_n);
    return d_n + 1;
  endfunction

endpackage

// File: rtl/sci_sync_fifo_th_if.sv
// Bus-side bundle of the SCI sync FIFO.
// slave = FIFO side, master = producer/consumer side.
interface sci_sync_fifo_th_if
  import sci_fifo_pkg::*;
#(
  parameter int N   = SCI_FIFO_N,
  parameter int D_N = SCI_FIFO_D_N
);

  logic           iREMOVE;
  logic           iERR_CLEAR;
  logic [D_N:0]   oCOUNT;
  logic           iWR_EN;
  logic [N-1:0]   iWR_DATA;
  logic           oWR_FULL;
  logic           oWR_ALMOST_FULL;
  logic           iRD_EN;
  logic [N-1:0]   oRD_DATA;
  logic           oRD_EMPTY;
  logic           oRD_ALMOST_EMPTY;
  logic           oOVERFLOW;
  logic           oUNDERFLOW;

  modport slave (
    input  iREMOVE,
    input  iERR_CLEAR,
    output oCOUNT,
    input  iWR_EN,
    input  iWR_DATA,
    output oWR_FULL,
    output oWR_ALMOST_FULL,
    input  iRD_EN,
    output oRD_DATA,
    output oRD_EMPTY,
    output oRD_ALMOST_EMPTY,
    output oOVERFLOW,
    output oUNDERFLOW
  );

  modport master (
    output iREMOVE,
    output iERR_CLEAR,
    input  oCOUNT,
    output iWR_EN,
    output iWR_DATA,
    input  oWR_FULL,
    input  oWR_ALMOST_FULL,
    output iRD_EN,
    input  oRD_DATA,
    input  oRD_EMPTY,
    input  oRD_ALMOST_EMPTY,
    input  oOVERFLOW,
    input  oUNDERFLOW
  );

endinterface

// File: rtl/sci_sync_fifo_ram.sv
// DEPTH x N register array for the SCI FIFO.
// One synchronous write port, one asynchronous read port.
module sci_sync_fifo_ram
  import sci_fifo_pkg::*;
#(
  parameter int N     = SCI_FIFO_N,
  parameter int D_N   = SCI_FIFO_D_N,
  parameter int DEPTH = 1 << D_N
) (
  input  logic           iCLOCK,
  input  logic           we,
  input  logic [D_N-1:0] waddr,
  input  logic [N-1:0]   wdata,
  input  logic [D_N-1:0] raddr,
  output logic [N-1:0]   rdata
);

  logic [N-1:0] mem_q [DEPTH];

  // Store accepted write data; contents survive reset and flush
  always_ff @(posedge iCLOCK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sci_sync_fifo_th.sv
// Synchronous FIFO with thresholds for SCI/UART TX and RX paths.
// Define SCI_SYNC_FIFO_ERROR_FLAG_EN to build sticky error flags.
module sci_sync_fifo_th
  import sci_fifo_pkg::*;
#(
  parameter int N     = SCI_FIFO_N,
  parameter int D_N   = SCI_FIFO_D_N,
  parameter int DEPTH = 1 << D_N,
  parameter int AF_TH = 3,
  parameter int AE_TH = 1
) (
  input  logic            iCLOCK,
  input  logic            inRESET,
  sci_sync_fifo_th_if.slave bus
);

  localparam int PW = sci_fifo_ptr_w(D_N);

  localparam logic [PW-1:0] FULL_V = PW'(DEPTH);
  localparam logic [PW-1:0] AF_V   = PW'(AF_TH);
  localparam logic [PW-1:0] AE_V   = PW'(AE_TH);

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          rd_ok;
  logic          wr_ok;
  logic          mem_we;

  assign count = wp_q - rp_q;
  assign full  = (count == FULL_V);
  assign empty = (count == '0);

  // A read on a full FIFO frees the slot the write needs
  assign rd_ok  = bus.iRD_EN & ~empty;
  assign wr_ok  = bus.iWR_EN & (~full | rd_ok);
  assign mem_we = wr_ok & ~bus.iREMOVE;

  // Next pointers: flush wins, otherwise advance on acceptance
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (bus.iREMOVE) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (wr_ok) wp_d = wp_q + 1'b1;
      if (rd_ok) rp_d = rp_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  sci_sync_fifo_ram #(
    .N     (N),
    .D_N   (D_N),
    .DEPTH (DEPTH)
  ) u_ram (
    .iCLOCK (iCLOCK),
    .we     (mem_we),
    .waddr  (wp_q[D_N-1:0]),
    .wdata  (bus.iWR_DATA),
    .raddr  (rp_q[D_N-1:0]),
    .rdata  (bus.oRD_DATA)
  );

  assign bus.oCOUNT           = count;
  assign bus.oWR_FULL         = full;
  assign bus.oWR_ALMOST_FULL  = (count >= AF_V);
  assign bus.oRD_EMPTY        = empty;
  assign bus.oRD_ALMOST_EMPTY = (count <= AE_V);

`ifdef SCI_SYNC_FIFO_ERROR_FLAG_EN

  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky flags: clear first so a same-cycle set wins
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.iERR_CLEAR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!bus.iREMOVE) begin
      if (bus.iWR_EN & ~wr_ok) ovf_d = 1'b1;
      if (bus.iRD_EN & ~rd_ok) unf_d = 1'b1;
    end
  end

  // Error flag registers
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.oOVERFLOW  = ovf_q;
  assign bus.oUNDERFLOW = unf_q;

`else

  logic unused_err_clear;
  assign unused_err_clear = bus.iERR_CLEAR;

  assign bus.oOVERFLOW  = 1'b0;
  assign bus.oUNDERFLOW = 1'b0;

`endif

endmodule
